nz_pwm_channel: RTL and testbench
=================================

// Module: nz_pwm_channel
// PURPOSE
//  Single PWM channel core sitting directly below tt_um_nz_pwm_generator: the top level decodes
//  ui_in/uio_in into period/duty/prescale words and hands them over via a valid/ready load port.
//  The block owns the prescaler, the period counter, period-synchronous (glitch-free) duty
//  update and the registered PWM outputs driven onto uo_out.
// PARAMETERS
//  WIDTH    8  bit width of period, duty and the main counter
//  PRESC_W  4  bit width of the prescaler divisor
//  DEAD_W   4  bit width of the dead-time count (used only with PWM_DEADTIME_EN)
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  rst_n        in   1        asynchronous, active-low reset
//  ena          in   1        run enable; 0 = counters held, outputs low
//  cfg_valid    in   1        load request
//  cfg_ready    out  1        shadow register free
//  cfg_period   in   WIDTH    counter terminal value (period = cfg_period+1 ticks)
//  cfg_duty     in   WIDTH    high-time in ticks
//  cfg_presc    in   PRESC_W  prescaler: one tick every cfg_presc+1 clk cycles
//  cfg_dead     in   DEAD_W   dead time in clk cycles (ignored without PWM_DEADTIME_EN)
//  pwm_out      out  1        PWM (high-side) output, registered
//  pwm_n_out    out  1        complementary low-side output, registered
//  period_tick  out  1        1-cycle pulse when the main counter wraps
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=0, cnt=0, active period={WIDTH{1}}, duty=0, presc=0, dead=0,
//    pending=0; pwm_out=0, pwm_n_out=0, period_tick=0, cfg_ready=1.
//  - Prescaler pc: if ena, pc==presc_act -> tick=1, pc<=0; else pc<=pc+1. presc_act=0 -> tick every clk.
//  - Counter cnt: on tick, cnt==period_act -> cnt<=0 (wrap), else cnt+1. wrap = tick & cnt==period_act.
//  - period_tick <= wrap (registered, asserted the cycle after the wrapping tick).
//  - raw = (cnt < duty_act), unsigned WIDTH compare. pwm_out <= raw: 1-cycle latency from cnt.
//    duty_act=0 -> constant low; duty_act > period_act -> constant high, no glitch at wrap.
//  - Load handshake: cfg_ready = ~pending. valid&ready -> shadow<=cfg_*, pending<=1 (next cycle ready=0).
//    valid while ready=0 is ignored (not queued); cfg_* need only be stable in the accept cycle.
//  - Apply: on wrap with pending=1 -> active<=shadow, pending<=0, cnt<=0, pc<=0; new values
//    govern the very next period. Accept and wrap in same cycle: shadow loads, applied at NEXT wrap.
//  - ena=0: pc, cnt held at 0, pwm_out/pwm_n_out <= 0, period_tick=0; a pending shadow is applied
//    the following cycle (no wrap needed). Handshake stays live. ena 0->1 restarts at cnt=0, pc=0.
//  - Reset mid-period or mid-handshake: everything returns to reset values; pending load discarded.
// CONFIGURATION
//  Macro PWM_DEADTIME_EN.
//  - Defined: complementary pair with dead time. On each raw edge a DEAD_W down-counter loads dead_act;
//    both outputs are 0 while it is non-zero. Then pwm_out<=raw, pwm_n_out<=~raw.
//    dead_act=0 -> pwm_n_out = ~pwm_out exactly. Any raw phase <= dead_act cycles is suppressed
//    (both outputs stay 0). dead_act is part of the shadow/active set. During ena=0 both outputs 0.
//  - Not defined: no dead-time logic; pwm_out <= raw; pwm_n_out tied 0; cfg_dead unused.
// TESTING (WIDTH=8, PRESC_W=4)
//  1 Reset, ena=1, no load -> pwm_out=0 always, cfg_ready=1, period_tick every 256 clk.
//  2 Load period=9 duty=3 presc=0 -> after next wrap pwm_out high 3 of every 10 clk, period_tick every 10.
//  3 Load duty=7 mid-period -> cfg_ready=0 until wrap, old duty holds to wrap, then high 7/10; 2nd valid dropped.
//  4 duty=0 -> constant 0; duty=10, period=9 -> constant 1 across wraps, no 1-cycle dip.
//  5 presc=2, period=9, duty=3 -> each count lasts 3 clk; 9 clk high / 30 clk period.
//  6 PWM_DEADTIME_EN, dead=2, period=9, duty=5 -> pwm_out high 3, pwm_n_out high 3, 2-clk both-low gaps;
//    macro off -> pwm_n_out=0 throughout.

Source files
------------

// File: rtl/nz_pwm_channel.sv
// nz_pwm_channel: prescaled PWM channel with period-synchronous shadow load; optional dead time via PWM_DEADTIME_EN
module nz_pwm_channel #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4,
  parameter int DEAD_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic [WIDTH-1:0]   cfg_duty,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic [DEAD_W-1:0]  cfg_dead,
  output logic               pwm_out,
  output logic               pwm_n_out,
  output logic               period_tick
);
  logic [PRESC_W-1:0] pc, presc_act, presc_sh;
  logic [WIDTH-1:0]   cnt, period_act, duty_act, period_sh, duty_sh;
  logic               pending, tick, wrap, accept, apply, raw;
  assign cfg_ready = ~pending;
  assign tick      = ena && pc == presc_act;
  assign wrap      = tick && cnt == period_act;
  assign accept    = cfg_valid && !pending;
  // while disabled there is no wrap to wait for, so a pending load goes straight in
  assign apply     = pending && (wrap || !ena);
  assign raw       = cnt < duty_act;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      cnt         <= '0;
      period_act  <= '1;
      duty_act    <= '0;
      presc_act   <= '0;
      period_sh   <= '0;
      duty_sh     <= '0;
      presc_sh    <= '0;
      pending     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      pc          <= (!ena || tick) ? '0 : pc + 1'b1;
      cnt         <= (!ena || wrap) ? '0 : tick ? cnt + 1'b1 : cnt;
      period_tick <= wrap;
      if (accept) begin
        period_sh <= cfg_period;
        duty_sh   <= cfg_duty;
        presc_sh  <= cfg_presc;
        pending   <= 1'b1;
      end
      if (apply) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
        presc_act  <= presc_sh;
        pending    <= 1'b0;
      end
    end
  end
`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0] dead_sh, dead_act, dcnt;
  logic              raw_q, flip, block;
  assign flip  = raw != raw_q;
  // the flip cycle itself is the first blanked cycle, so dcnt covers the remaining dead_act-1
  assign block = flip ? dead_act != '0 : dcnt != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_sh   <= '0;
      dead_act  <= '0;
      dcnt      <= '0;
      raw_q     <= 1'b0;
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
    end else begin
      if (accept) dead_sh <= cfg_dead;
      if (apply) dead_act <= dead_sh;
      raw_q     <= ena && raw;
      dcnt      <= !ena ? '0 : flip ? dead_act - DEAD_W'(dead_act != '0) : dcnt - DEAD_W'(dcnt != '0);
      pwm_out   <= ena && raw && !block;
      pwm_n_out <= ena && !raw && !block;
    end
  end
`else
  logic unused_dead;
  assign unused_dead = ^cfg_dead;
  assign pwm_n_out   = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= 1'b0;
    else pwm_out <= ena && raw;
  end
`endif
endmodule

// File: tb/tb_nz_pwm_channel.sv
// tb_nz_pwm_channel: directed checks of nz_pwm_channel (WIDTH=8, PRESC_W=4); honours PWM_DEADTIME_EN
module tb_nz_pwm_channel;
`ifdef PWM_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, cfg_valid = 1'b0;
  logic       cfg_ready, pwm_out, pwm_n_out, period_tick;
  logic [7:0] cfg_period = '0, cfg_duty = '0;
  logic [3:0] cfg_presc = '0, cfg_dead = '0;
  int         tests = 0, fails = 0, hi, nh, tk;

  nz_pwm_channel #(.WIDTH(8), .PRESC_W(4), .DEAD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_presc(cfg_presc), .cfg_dead(cfg_dead),
    .pwm_out(pwm_out), .pwm_n_out(pwm_n_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic measure(input int n);
    hi = 0; nh = 0; tk = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hi += int'(pwm_out);
      nh += int'(pwm_n_out);
      tk += int'(period_tick);
    end
  endtask

  task automatic wait_tick(input string tag, input int budget);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!period_tick && k < budget);
    check(tag, int'(period_tick), 1);
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] d, input logic [3:0] ps, input logic [3:0] dd);
    cfg_period = p; cfg_duty = d; cfg_presc = ps; cfg_dead = dd; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_pwm_n", int'(pwm_n_out), 0);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_tick", int'(period_tick), 0);
    @(negedge clk) rst_n = 1'b1;
    // 1: default period of 256, zero duty
    measure(512);
    check("t1_hi", hi, 0);
    check("t1_ticks", tk, 2);
    check("t1_ready", int'(cfg_ready), 1);
    // 2: period 9, duty 3
    load(8'd9, 8'd3, 4'd0, 4'd0);
    check("t2_busy", int'(cfg_ready), 0);
    wait_tick("t2_sync", 300);
    check("t2_ready", int'(cfg_ready), 1);
    measure(30);
    check("t2_hi", hi, 9);
    check("t2_ticks", tk, 3);
    check("t2_n", nh, DT ? 21 : 0);
    // 3: mid-period duty change, second request while busy is dropped
    wait_tick("t3_sync", 20);
    load(8'd9, 8'd7, 4'd0, 4'd0);
    check("t3_busy1", int'(cfg_ready), 0);
    load(8'd9, 8'd1, 4'd0, 4'd0);
    check("t3_busy2", int'(cfg_ready), 0);
    measure(8);
    check("t3_old_hi", hi, 1);
    check("t3_wrap", tk, 1);
    check("t3_ready", int'(cfg_ready), 1);
    measure(30);
    check("t3_hi", hi, 21);
    check("t3_ticks", tk, 3);
    // 4: duty extremes
    load(8'd9, 8'd0, 4'd0, 4'd0);
    wait_tick("t4a_sync", 20);
    measure(30);
    check("t4_zero_hi", hi, 0);
    check("t4_zero_ticks", tk, 3);
    load(8'd9, 8'd10, 4'd0, 4'd0);
    wait_tick("t4b_sync", 20);
    measure(30);
    check("t4_full_hi", hi, 30);
    check("t4_full_ticks", tk, 3);
    // 5: prescaler of 3
    load(8'd9, 8'd3, 4'd2, 4'd0);
    wait_tick("t5_sync", 20);
    measure(29);
    check("t5_hi", hi, 9);
    check("t5_no_tick", tk, 0);
    measure(1);
    check("t5_tick", tk, 1);
    // disabled: outputs low, load applied without a wrap, restart from zero
    ena = 1'b0;
    measure(3);
    check("dis_hi", hi, 0);
    check("dis_n", nh, 0);
    check("dis_ticks", tk, 0);
    load(8'd4, 8'd2, 4'd0, 4'd0);
    check("dis_busy", int'(cfg_ready), 0);
    measure(1);
    check("dis_applied", int'(cfg_ready), 1);
    ena = 1'b1;
    measure(5);
    check("en_hi", hi, 2);
    check("en_tick", tk, 1);
    measure(10);
    check("en_hi2", hi, 4);
    check("en_ticks2", tk, 2);
    // async reset mid-handshake discards the pending load
    load(8'd9, 8'd5, 4'd0, 4'd0);
    #3 rst_n = 1'b0;
    #1;
    check("ar_ready", int'(cfg_ready), 1);
    check("ar_pwm", int'(pwm_out), 0);
    check("ar_tick", int'(period_tick), 0);
    @(negedge clk) rst_n = 1'b1;
    measure(260);
    check("ar_hi", hi, 0);
    check("ar_ticks", tk, 1);
    // 6: dead time 2, period 9, duty 5
    load(8'd9, 8'd5, 4'd0, 4'd2);
    wait_tick("t6_sync", 300);
    measure(10);
    measure(30);
    check("t6_hi", hi, DT ? 9 : 15);
    check("t6_n", nh, DT ? 9 : 0);
    check("t6_ticks", tk, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
